// File: rtl/instruction_queue.sv
// Fetch-side instruction queue feeding the reorder buffer.
// Drives the instruction-memory read port, buffers fetched words as decoded
// pci_t entries in a circular FIFO and presents the head entry to the ROB.
// An empty queue forwards a same-cycle memory response straight to the head.

package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic [31:0] instr;
        rv32i_opcode opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] i_imm;
        logic [31:0] s_imm;
        logic [31:0] b_imm;
        logic [31:0] u_imm;
        logic [31:0] j_imm;
    } pci_t;

    // Build a fully decoded entry from a fetch address and instruction word.
    function automatic pci_t decode_pci(input logic [31:0] pc, input logic [31:0] instr);
        pci_t p;
        p.pc      = pc;
        p.next_pc = pc + 32'd4;
        p.instr   = instr;
        p.opcode  = rv32i_opcode'(instr[6:0]);
        p.funct3  = instr[14:12];
        p.funct7  = instr[31:25];
        p.rs1     = instr[19:15];
        p.rs2     = instr[24:20];
        p.rd      = instr[11:7];
        p.i_imm   = {{21{instr[31]}}, instr[30:20]};
        p.s_imm   = {{21{instr[31]}}, instr[30:25], instr[11:7]};
        p.b_imm   = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        p.u_imm   = {instr[31:12], 12'h000};
        p.j_imm   = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        return p;
    endfunction

    // Head value shown when nothing is available: op_imm with everything else
    // zero, so the ROB never mistakes it for a real instruction.
    function automatic pci_t empty_pci();
        pci_t p;
        p        = '0;
        p.opcode = op_imm;
        return p;
    endfunction

endpackage

module instruction_queue
    import rv32i_types::*;
#(
    parameter int          size     = 8,
    parameter logic [31:0] RESET_PC = 32'h00000060
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        instr_mem_resp,
    input  logic [31:0] instr_mem_rdata,
    input  logic        instr_q_dequeue,
    output logic        instr_mem_read,
    output logic [31:0] instr_mem_address,
    output logic        instr_q_empty,
    output logic        instr_q_full,
    output pci_t        pci
);

    localparam int PTR_W = $clog2(size);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(size);

    typedef enum logic [1:0] {
        FETCH,
        STALL,
        DISCARD
    } state_t;

    state_t            state;
    logic [31:0]       fetch_pc;
    logic [31:0]       saved_pc;
    pci_t              arr [size];
    logic [PTR_W-1:0]  front;
    logic [PTR_W-1:0]  rear;
    logic [CNT_W-1:0]  count;

    logic              in_fetch;
    logic              queue_zero;
    logic              bypass;
    logic              do_enq;
    logic              do_deq;
    logic              outstanding;
    logic [CNT_W-1:0]  count_next;
    pci_t              incoming;

    assign instr_mem_address = fetch_pc;
    assign instr_q_empty     = (count == '0);
    assign instr_q_full      = (count == SIZE_C);

    // Decode control: which queue operations happen this cycle. Flush masks
    // every enqueue/dequeue/bypass, and a bypassed word that the ROB takes in
    // the same cycle never lands in storage.
    always_comb begin
        in_fetch    = (state == FETCH);
        queue_zero  = (count == '0);
        bypass      = !rst && !flush && in_fetch && instr_mem_resp && queue_zero;
        do_enq      = !flush && in_fetch && instr_mem_resp && !(queue_zero && instr_q_dequeue);
        do_deq      = !flush && instr_q_dequeue && !queue_zero;
        outstanding = (state == FETCH) || (state == DISCARD);
        count_next  = count + {{(CNT_W-1){1'b0}}, do_enq} - {{(CNT_W-1){1'b0}}, do_deq};
        incoming    = decode_pci(fetch_pc, instr_mem_rdata);
    end

    // Read request is a decode of the state, forced low while reset is held.
    always_comb begin
        instr_mem_read = !rst && outstanding;
    end

    // Head output: stored head if any, otherwise the bypassed response, otherwise the idle value.
    always_comb begin
        pci = empty_pci();
        if (!queue_zero) begin
            pci = arr[front];
        end else if (bypass) begin
            pci = incoming;
        end
    end

    // Entry storage carries no reset; count and pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (!rst && do_enq) begin
            arr[rear] <= incoming;
        end
    end

    // Fetch FSM, fetch address, redirect bookkeeping and queue pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            saved_pc <= '0;
            front    <= '0;
            rear     <= '0;
            count    <= '0;
        end else if (flush) begin
            front <= '0;
            rear  <= '0;
            count <= '0;
            if (outstanding && !instr_mem_resp) begin
                saved_pc <= flush_pc;
                state    <= DISCARD;
            end else begin
                fetch_pc <= flush_pc;
                state    <= FETCH;
            end
        end else begin
            if (do_enq) begin
                rear <= rear + PTR_W'(1);
            end
            if (do_deq) begin
                front <= front + PTR_W'(1);
            end
            count <= count_next;
            case (state)
                FETCH: begin
                    if (instr_mem_resp) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        state    <= (count_next == SIZE_C) ? STALL : FETCH;
                    end
                end
                STALL: begin
                    if (count < SIZE_C) begin
                        state <= FETCH;
                    end
                end
                DISCARD: begin
                    if (instr_mem_resp) begin
                        fetch_pc <= saved_pc;
                        state    <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule
